// File: rtl/top_ej1_fp13_mul_pkg.sv
// Shared format constants and field helpers for the 13-bit float {sign, exp[3:0], frac[7:0]}.
package top_ej1_fp13_mul_pkg;

    localparam int FP_W     = 13;
    localparam int EXP_W    = 4;
    localparam int FRAC_W   = 8;
    localparam int EXPC_W   = 7;
    localparam logic signed [EXPC_W-1:0] BIAS    = 7'sd7;
    localparam logic signed [EXPC_W-1:0] EXP_MAX = 7'sd15;
    localparam logic [FP_W-1:0]   ZERO     = 13'd0;
    localparam logic [FRAC_W-1:0] SAT_FRAC = 8'hFF;

    function automatic logic getSign(input logic [FP_W-1:0] v);
        return v[FP_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] getExp(input logic [FP_W-1:0] v);
        return v[FP_W-2:FRAC_W];
    endfunction

    function automatic logic [FRAC_W-1:0] getFrac(input logic [FP_W-1:0] v);
        return v[FRAC_W-1:0];
    endfunction

endpackage

// File: rtl/fp13_mul_core.sv
// Combinational fp13 multiply: unpack, multiply mantissas, normalise, round-to-nearest-even,
// then saturate on overflow or flush to +0 on underflow or zero operands.
module fp13_mul_core
    import top_ej1_fp13_mul_pkg::*;
(
    input  logic [FP_W-1:0] a_i,
    input  logic [FP_W-1:0] b_i,
    output logic [FP_W-1:0] p_o
);

    logic                     signP;
    logic [EXP_W-1:0]         expA;
    logic [EXP_W-1:0]         expB;
    logic [2*FRAC_W+1:0]      prod;
    logic                     normShift;
    logic [FRAC_W:0]          mantTrunc;
    logic                     guardBit;
    logic                     stickyBit;
    logic                     roundUp;
    logic [FRAC_W+1:0]        mantRound;
    logic                     roundCarry;
    logic [FRAC_W-1:0]        fracOut;
    logic signed [EXPC_W-1:0] expOut;

    always_comb begin
        signP     = getSign(a_i) ^ getSign(b_i);
        expA      = getExp(a_i);
        expB      = getExp(b_i);
        prod      = {1'b1, getFrac(a_i)} * {1'b1, getFrac(b_i)};
        normShift = prod[2*FRAC_W+1];

        if (normShift) begin
            mantTrunc = prod[2*FRAC_W+1:FRAC_W+1];
            guardBit  = prod[FRAC_W];
            stickyBit = |prod[FRAC_W-1:0];
        end else begin
            mantTrunc = prod[2*FRAC_W:FRAC_W];
            guardBit  = prod[FRAC_W-1];
            stickyBit = |prod[FRAC_W-2:0];
        end

        roundUp    = guardBit & (stickyBit | mantTrunc[0]);
        mantRound  = {1'b0, mantTrunc} + {{FRAC_W+1{1'b0}}, roundUp};
        roundCarry = mantRound[FRAC_W+1];
        fracOut    = roundCarry ? mantRound[FRAC_W:1] : mantRound[FRAC_W-1:0];

        // Widened signed exponent so sums beyond 15 or below 1 never wrap.
        expOut = $signed({3'b000, expA}) + $signed({3'b000, expB}) - BIAS
               + $signed({6'b000000, normShift}) + $signed({6'b000000, roundCarry});

        if (expA == '0 || expB == '0 || expOut < 7'sd1) begin
            p_o = ZERO;
        end else if (expOut > EXP_MAX) begin
            p_o = {signP, 4'hF, SAT_FRAC};
        end else begin
            p_o = {signP, expOut[EXP_W-1:0], fracOut};
        end
    end

endmodule

// File: rtl/top_ej1_fp13_mul.sv
// Exercise 1 top: fp13 multiply core followed by a single output register with async clear.
module top_ej1_fp13_mul
    import top_ej1_fp13_mul_pkg::*;
(
    input  logic            clock,
    input  logic            i_rst_n,
    input  logic [FP_W-1:0] i_flotante_1,
    input  logic [FP_W-1:0] i_flotante_2,
    output logic [FP_W-1:0] o_mutiplicado
);

    logic [FP_W-1:0] result_d;
    logic [FP_W-1:0] result_q;

    fp13_mul_core u_core (
        .a_i (i_flotante_1),
        .b_i (i_flotante_2),
        .p_o (result_d)
    );

    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= ZERO;
        end else begin
            result_q <= result_d;
        end
    end

    assign o_mutiplicado = result_q;

endmodule

// File: tb/tb_top_ej1_fp13_mul.sv
// Directed self-checking bench for top_ej1_fp13_mul with hand-computed products.
module tb_top_ej1_fp13_mul;

    logic        clock;
    logic        i_rst_n;
    logic [12:0] i_flotante_1;
    logic [12:0] i_flotante_2;
    logic [12:0] o_mutiplicado;

    int passCount;
    int checkCount;

    top_ej1_fp13_mul dut (
        .clock         (clock),
        .i_rst_n       (i_rst_n),
        .i_flotante_1  (i_flotante_1),
        .i_flotante_2  (i_flotante_2),
        .o_mutiplicado (o_mutiplicado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive on the falling edge, sample 1 ns after the following rising edge.
    task automatic mulOnce(input logic [12:0] a, input logic [12:0] b, input logic [12:0] expected,
                           input string name);
        @(negedge clock);
        i_flotante_1 = a;
        i_flotante_2 = b;
        @(posedge clock);
        #1;
        checkCount++;
        if (o_mutiplicado !== expected)
            $display("[TB] FAIL %s: got %b expected %b", name, o_mutiplicado, expected);
        else
            passCount++;
    endtask

    task automatic test_reset();
        i_rst_n      = 1'b0;
        i_flotante_1 = 13'b0_0111_10000000;
        i_flotante_2 = 13'b0_0111_10000000;
        repeat (3) @(posedge clock);
        #1;
        checkCount++;
        if (o_mutiplicado !== 13'd0)
            $display("[TB] FAIL reset_hold: got %b expected %b", o_mutiplicado, 13'd0);
        else
            passCount++;
        @(negedge clock);
        i_rst_n = 1'b1;
    endtask

    task automatic test_products();
        logic [12:0] aVec [4];
        logic [12:0] bVec [4];
        logic [12:0] pVec [4];
        aVec[0] = 13'b1_0101_11000110; bVec[0] = 13'b0_1100_00011101; pVec[0] = 13'b1_1010_11111001;
        aVec[1] = 13'b0_0011_11001101; bVec[1] = 13'b1_1011_00101011; pVec[1] = 13'b1_1000_00001101;
        aVec[2] = 13'b0_1100_00011101; bVec[2] = 13'b0_0011_11001101; pVec[2] = 13'b0_1001_00000001;
        aVec[3] = 13'b1_0101_11000110; bVec[3] = 13'b1_1011_00101011; pVec[3] = 13'b0_1010_00001001;
        for (int i = 0; i < 4; i++) begin
            mulOnce(aVec[i], bVec[i], pVec[i], $sformatf("product_%0d", i));
            mulOnce(bVec[i], aVec[i], pVec[i], $sformatf("product_swapped_%0d", i));
        end
    endtask

    task automatic test_rounding();
        mulOnce(13'b0_0111_10000000, 13'b0_0111_10000000, 13'b0_1000_00100000, "normalise_1p5sq");
        mulOnce(13'b0_0111_10000000, 13'b0_0111_00000001, 13'b0_0111_10000010, "tie_round_up_odd");
        mulOnce(13'b0_0111_10000000, 13'b0_0111_00000011, 13'b0_0111_10000100, "tie_stay_even");
        mulOnce(13'b0_0111_01101010, 13'b0_0111_01101010, 13'b0_1000_00000000, "round_carry_out");
    endtask

    task automatic test_edge_cases();
        mulOnce(13'd0, 13'b0_1100_00011101, 13'd0, "zero_a");
        mulOnce(13'b1_1100_00011101, 13'b0_0000_11111111, 13'd0, "zero_b_ignores_frac");
        mulOnce(13'b0_1111_00000000, 13'b0_1111_00000000, 13'b0_1111_11111111, "saturate_pos");
        mulOnce(13'b1_1111_00000000, 13'b0_1111_00000000, 13'b1_1111_11111111, "saturate_neg");
        mulOnce(13'b0_1011_00000000, 13'b0_1011_00000000, 13'b0_1111_00000000, "exp_max_exact");
        mulOnce(13'b0_0100_00000000, 13'b0_0100_00000000, 13'b0_0001_00000000, "exp_min_exact");
        mulOnce(13'b0_0001_00000000, 13'b0_0001_00000000, 13'd0, "underflow");
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        i_flotante_1 = 13'b0_0111_10000000;
        i_flotante_2 = 13'b0_0111_10000000;
        @(posedge clock);
        #3;
        i_rst_n = 1'b0;
        #1;
        checkCount++;
        if (o_mutiplicado !== 13'd0)
            $display("[TB] FAIL async_reset_immediate: got %b expected %b", o_mutiplicado, 13'd0);
        else
            passCount++;
        @(posedge clock);
        #1;
        checkCount++;
        if (o_mutiplicado !== 13'd0)
            $display("[TB] FAIL async_reset_held: got %b expected %b", o_mutiplicado, 13'd0);
        else
            passCount++;
        @(negedge clock);
        i_rst_n = 1'b1;
        #2;
        checkCount++;
        if (o_mutiplicado !== 13'd0)
            $display("[TB] FAIL async_reset_released: got %b expected %b", o_mutiplicado, 13'd0);
        else
            passCount++;
        @(posedge clock);
        #1;
        checkCount++;
        if (o_mutiplicado !== 13'b0_1000_00100000)
            $display("[TB] FAIL async_reset_first_edge: got %b expected %b",
                     o_mutiplicado, 13'b0_1000_00100000);
        else
            passCount++;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        test_reset();
        test_products();
        test_rounding();
        test_edge_cases();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
